dcache_access_ctrl: RTL and testbench

Sequencer and arbiter for the data cache port. It sits between two requesters, the LSQ load-issue port and the ROB store-retire port, and the single shared port of the 4-way data cache. It serialises accesses, handles load misses by fetching from main memory and filling the cache, and returns load results with their ROB tag. It also keeps saturating hit and miss counters.

---
 rtl/dcache_ctrl_pkg.sv | 44 ++++
 rtl/dcache_access_ctrl_if.sv | 66 ++++++
 rtl/sat_counter.sv | 20 ++
 rtl/dcache_access_ctrl.sv | 173 +++++++++++++++++
 tb/tb_dcache_access_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared types, encodings and helpers for the data-cache access controller.
package dcache_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    // Access size encoding, shared by loads, stores and the cache port
    localparam logic SIZE_HALF = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;

    // Which requester won the most recent arbitration
    localparam logic GRANT_LOAD  = 1'b0;
    localparam logic GRANT_STORE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_CHECK,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_FILL,
        S_RESP,
        S_ST_WRITE
    } state_e;

    // Latched load request held for the whole access
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              size;
    } ld_req_t;

    // Zero-extend the addressed byte or halfword of a 32-bit word
    function automatic logic [DATA_W-1:0] mask_data(input logic [DATA_W-1:0] d,
                                                    input logic              size);
        logic [DATA_W-1:0] r;
        if (size == SIZE_BYTE) begin
            r = {24'h0, d[7:0]};
        end else begin
            r = {16'h0, d[15:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/dcache_access_ctrl_if.sv
// Requester, cache-port and memory-port signals of the access controller.
interface dcache_access_ctrl_if #(
    parameter int unsigned TAG_W = 6
) ();
    import dcache_ctrl_pkg::*;

    // load issue port
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_size;
    logic [TAG_W-1:0]  ld_tag;

    // store retire port
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_size;

    // load response
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic [TAG_W-1:0]  resp_tag;
    logic              resp_err;

    // data cache port
    logic              cache_rd;
    logic              cache_wr;
    logic [ADDR_W-1:0] cache_addr;
    logic [DATA_W-1:0] cache_wdata;
    logic              cache_size;
    logic [DATA_W-1:0] cache_rdata;
    logic              cache_miss;

    // main memory port
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_rdata;

    // controller side
    modport slave (
        input  ld_valid, ld_addr, ld_size, ld_tag,
        input  st_valid, st_addr, st_data, st_size,
        input  cache_rdata, cache_miss,
        input  mem_valid, mem_rdata,
        output ld_ready, st_ready,
        output resp_valid, resp_data, resp_tag, resp_err,
        output cache_rd, cache_wr, cache_addr, cache_wdata, cache_size,
        output mem_req, mem_addr
    );

    // requester / cache / memory side
    modport master (
        output ld_valid, ld_addr, ld_size, ld_tag,
        output st_valid, st_addr, st_data, st_size,
        output cache_rdata, cache_miss,
        output mem_valid, mem_rdata,
        input  ld_ready, st_ready,
        input  resp_valid, resp_data, resp_tag, resp_err,
        input  cache_rd, cache_wr, cache_addr, cache_wdata, cache_size,
        input  mem_req, mem_addr
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // increment on each event until saturated
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/dcache_access_ctrl.sv
// Arbitrates load/store requesters onto the single data-cache port,
// services load misses from main memory and returns tagged load results.
module dcache_access_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int unsigned TAG_W   = 6,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    dcache_access_ctrl_if.slave  bus,
    output logic [CNT_W-1:0]     hit_cnt,
    output logic [CNT_W-1:0]     miss_cnt
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    state_e           state;
    logic             last_grant;
    ld_req_t          ld_req;
    logic [TAG_W-1:0] ld_tag;
    logic [TMR_W-1:0] timer;

    logic ld_ready_c;
    logic st_ready_c;
    logic ld_fire_c;
    logic st_fire_c;
    logic hit_inc_c;
    logic miss_inc_c;

    // round-robin arbitration between the two requesters, only while idle
    always_comb begin
        ld_ready_c = (state == S_IDLE) && (!bus.st_valid || (last_grant == GRANT_STORE));
        st_ready_c = (state == S_IDLE) && (!bus.ld_valid || (last_grant == GRANT_LOAD));
        ld_fire_c  = bus.ld_valid && ld_ready_c;
        st_fire_c  = bus.st_valid && st_ready_c;
        hit_inc_c  = (state == S_CHECK) && !bus.cache_miss;
        miss_inc_c = (state == S_CHECK) && bus.cache_miss;
    end

    assign bus.ld_ready = ld_ready_c;
    assign bus.st_ready = st_ready_c;

    // access sequencer; outputs are loaded on entry to the state that owns them
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= S_IDLE;
            last_grant      <= GRANT_STORE;
            ld_req          <= '0;
            ld_tag          <= '0;
            timer           <= '0;
            bus.resp_valid  <= 1'b0;
            bus.resp_data   <= '0;
            bus.resp_tag    <= '0;
            bus.resp_err    <= 1'b0;
            bus.cache_rd    <= 1'b0;
            bus.cache_wr    <= 1'b0;
            bus.cache_addr  <= '0;
            bus.cache_wdata <= '0;
            bus.cache_size  <= 1'b0;
            bus.mem_req     <= 1'b0;
            bus.mem_addr    <= '0;
        end else begin
            bus.cache_rd   <= 1'b0;
            bus.cache_wr   <= 1'b0;
            bus.mem_req    <= 1'b0;
            bus.resp_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (ld_fire_c) begin
                        ld_req.addr    <= bus.ld_addr;
                        ld_req.size    <= bus.ld_size;
                        ld_tag         <= bus.ld_tag;
                        last_grant     <= GRANT_LOAD;
                        bus.cache_rd   <= 1'b1;
                        bus.cache_addr <= bus.ld_addr;
                        bus.cache_size <= bus.ld_size;
                        state          <= S_LOOKUP;
                    end else if (st_fire_c) begin
                        last_grant      <= GRANT_STORE;
                        bus.cache_wr    <= 1'b1;
                        bus.cache_addr  <= bus.st_addr;
                        bus.cache_wdata <= bus.st_data;
                        bus.cache_size  <= bus.st_size;
                        state           <= S_ST_WRITE;
                    end
                end

                S_LOOKUP: begin
                    state <= S_CHECK;
                end

                S_CHECK: begin
                    if (bus.cache_miss) begin
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= ld_req.addr;
                        state        <= S_MEM_REQ;
                    end else begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_data  <= mask_data(bus.cache_rdata, ld_req.size);
                        bus.resp_tag   <= ld_tag;
                        bus.resp_err   <= 1'b0;
                        state          <= S_RESP;
                    end
                end

                S_MEM_REQ: begin
                    timer <= TMR_W'(1);
                    state <= S_MEM_WAIT;
                end

                // memory data beats the timeout when both land in the same cycle
                S_MEM_WAIT: begin
                    if (bus.mem_valid) begin
                        bus.cache_wr    <= 1'b1;
                        bus.cache_addr  <= ld_req.addr;
                        bus.cache_wdata <= mask_data(bus.mem_rdata, ld_req.size);
                        bus.cache_size  <= ld_req.size;
                        timer           <= '0;
                        state           <= S_FILL;
                    end else if (timer == TMR_W'(TIMEOUT)) begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_data  <= '0;
                        bus.resp_tag   <= ld_tag;
                        bus.resp_err   <= 1'b1;
                        timer          <= '0;
                        state          <= S_RESP;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

                // fill data is already masked in cache_wdata
                S_FILL: begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_data  <= bus.cache_wdata;
                    bus.resp_tag   <= ld_tag;
                    bus.resp_err   <= 1'b0;
                    state          <= S_RESP;
                end

                S_RESP: begin
                    state <= S_IDLE;
                end

                S_ST_WRITE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (hit_inc_c),
        .cnt  (hit_cnt)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (miss_inc_c),
        .cnt  (miss_cnt)
    );

endmodule

// File: tb/tb_dcache_access_ctrl.sv
// Bench for dcache_access_ctrl: behavioural cache/memory responders and a
// transaction-level model of expected responses, latencies and counters.
module tb_dcache_access_ctrl;

    localparam int unsigned TAG_W   = 6;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rstn;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    always #5 clk = ~clk;

    dcache_access_ctrl_if #(.TAG_W(TAG_W)) bus ();

    dcache_access_ctrl #(
        .TAG_W   (TAG_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ext(input logic [31:0] d, input logic sz);
        return d & (sz ? 32'h0000_00FF : 32'h0000_FFFF);
    endfunction

    function automatic int sat(input int n);
        return (n > int'(CNT_MAX)) ? int'(CNT_MAX) : n;
    endfunction

    // ---------------- cache responder: answers one cycle after a read strobe
    logic [31:0] cache_arr [logic [31:0]];

    initial begin
        logic        rd, wr;
        logic [31:0] a, d;
        bus.cache_miss  = 1'b0;
        bus.cache_rdata = '0;
        forever begin
            @(negedge clk);
            rd = bus.cache_rd;
            wr = bus.cache_wr;
            a  = bus.cache_addr;
            d  = bus.cache_wdata;
            @(posedge clk);
            #1;
            if (wr) cache_arr[a] = d;
            if (rd) begin
                if (cache_arr.exists(a)) begin
                    bus.cache_miss  = 1'b0;
                    bus.cache_rdata = cache_arr[a];
                end else begin
                    bus.cache_miss  = 1'b1;
                    bus.cache_rdata = $urandom;
                end
            end
        end
    end

    // ---------------- memory responder: mem_lat cycles after mem_req (0 = never)
    int          mem_lat  = 1;
    logic [31:0] mem_word = '0;

    initial begin
        bus.mem_valid = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req && mem_lat > 0) begin
                repeat (mem_lat) @(posedge clk);
                #1;
                bus.mem_valid = 1'b1;
                bus.mem_rdata = mem_word;
                @(posedge clk);
                #1;
                bus.mem_valid = 1'b0;
                bus.mem_rdata = $urandom;
            end
        end
    end

    // ---------------- monitor
    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
        int               cyc;
    } resp_t;

    resp_t       rq[$];
    logic [31:0] wq[$];
    int          wcyc[$];
    logic        gq[$];
    int          mem_req_cnt = 0;

    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (bus.resp_valid) begin
                r.data = bus.resp_data;
                r.tag  = bus.resp_tag;
                r.err  = bus.resp_err;
                r.cyc  = cyc;
                rq.push_back(r);
            end
            if (bus.cache_wr) begin
                wq.push_back(bus.cache_wdata);
                wcyc.push_back(cyc);
            end
            if (bus.mem_req) mem_req_cnt++;
            if (bus.ld_valid && bus.ld_ready) gq.push_back(1'b0);
            if (bus.st_valid && bus.st_ready) gq.push_back(1'b1);
        end
    end

    // ---------------- reference model state
    logic [31:0] model_cache [logic [31:0]];
    int          n_hit  = 0;
    int          n_miss = 0;

    // present one request and return the cycle in which it was accepted
    task automatic do_req(input bit is_st, input logic [31:0] addr, input logic [31:0] data,
                          input logic size, input logic [TAG_W-1:0] tag, output int acc);
        @(posedge clk);
        #1;
        if (is_st) begin
            bus.st_valid = 1'b1; bus.st_addr = addr; bus.st_data = data; bus.st_size = size;
        end else begin
            bus.ld_valid = 1'b1; bus.ld_addr = addr; bus.ld_size = size; bus.ld_tag = tag;
        end
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (is_st ? bus.st_ready : bus.ld_ready) begin
                acc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.st_valid = 1'b0;
        bus.ld_valid = 1'b0;
        check_eq("accept", 32'(acc >= 0), 32'd1);
    endtask

    task automatic run_store(input logic [31:0] addr, input logic [31:0] data, input logic size);
        int acc;
        repeat (2) @(posedge clk);
        wq.delete();
        wcyc.delete();
        do_req(1'b1, addr, data, size, '0, acc);
        repeat (2) @(negedge clk);
        check_eq("st_wr_count", 32'(wq.size()), 32'd1);
        check_eq("st_wdata", (wq.size() > 0) ? wq[0] : 32'hxxxx_xxxx, data);
        check_eq("st_wr_cycle", (wcyc.size() > 0) ? 32'(wcyc[0] - acc) : 32'hFFFF_FFFF, 32'd1);
        model_cache[addr] = data;
    endtask

    task automatic run_load(input logic [31:0] addr, input logic size, input logic [TAG_W-1:0] tag,
                            input int lat, input logic [31:0] mdata);
        int          acc, m0, exp_off, wait_i;
        bit          hit, tmo, fill;
        logic [31:0] exp_data;
        resp_t       r;
        repeat (4) @(posedge clk);
        rq.delete();
        wq.delete();
        wcyc.delete();
        m0       = mem_req_cnt;
        mem_lat  = lat;
        mem_word = mdata;

        hit      = model_cache.exists(addr);
        tmo      = !hit && (lat == 0 || lat > int'(TIMEOUT));
        fill     = !hit && !tmo;
        exp_data = hit ? ext(model_cache[addr], size) : (tmo ? 32'h0 : ext(mdata, size));
        exp_off  = hit ? 3 : (tmo ? int'(TIMEOUT) + 4 : lat + 5);

        do_req(1'b0, addr, '0, size, tag, acc);
        wait_i = 0;
        while (rq.size() == 0 && wait_i < exp_off + 20) begin
            @(posedge clk);
            wait_i++;
        end
        repeat (4) @(negedge clk);

        if (rq.size() > 0) begin
            r = rq[0];
        end else begin
            r.data = 'x; r.tag = 'x; r.err = 1'bx; r.cyc = -1;
        end
        check_eq("resp_count", 32'(rq.size()), 32'd1);
        check_eq("resp_data", r.data, exp_data);
        check_eq("resp_tag", 32'(r.tag), 32'(tag));
        check_eq("resp_err", 32'(r.err), 32'(tmo));
        check_eq("resp_latency", 32'(r.cyc - acc), 32'(exp_off));
        check_eq("mem_req_count", 32'(mem_req_cnt - m0), hit ? 32'd0 : 32'd1);
        check_eq("fill_count", 32'(wq.size()), 32'(fill));
        if (fill) begin
            check_eq("fill_wdata", (wq.size() > 0) ? wq[0] : 32'hxxxx_xxxx, exp_data);
            model_cache[addr] = exp_data;
        end
        if (hit) n_hit++; else n_miss++;
        check_eq("hit_cnt", 32'(hit_cnt), 32'(sat(n_hit)));
        check_eq("miss_cnt", 32'(miss_cnt), 32'(sat(n_miss)));
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        n_hit  = 0;
        n_miss = 0;
    endtask

    // watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int acc, m0, lat;
        logic [31:0] a;
        rstn = 1'b0;
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_size = 1'b0; bus.ld_tag = '0;
        bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0; bus.st_size = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("rst_cache_rd", 32'(bus.cache_rd), 32'd0);
        check_eq("rst_cache_wr", 32'(bus.cache_wr), 32'd0);
        check_eq("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check_eq("rst_resp_data", bus.resp_data, 32'd0);
        check_eq("rst_counters", 32'({hit_cnt, miss_cnt}), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check_eq("idle_ld_ready", 32'(bus.ld_ready), 32'd1);
        check_eq("idle_st_ready", 32'(bus.st_ready), 32'd1);

        // store then load hit at the same address
        run_store(32'h0000_2040, 32'h0000_1234, 1'b0);
        run_load(32'h0000_2040, 1'b0, 6'd5, 4, 32'hAAAA_AAAA);

        // byte miss serviced from memory, then a hit on the refilled line
        run_load(32'h0001_0000, 1'b1, 6'd9, 4, 32'hDEAD_BEEF);
        run_load(32'h0001_0000, 1'b1, 6'd10, 4, 32'h1111_1111);

        // timeout, minimum latency and timeout boundaries
        run_load(32'h0003_0000, 1'b0, 6'd12, 0, 32'h0);
        run_load(32'h0007_0000, 1'b0, 6'd15, 1, 32'hCAFE_F00D);
        run_load(32'h0004_0000, 1'b1, 6'd13, int'(TIMEOUT), 32'h1234_5678);
        run_load(32'h0005_0000, 1'b0, 6'd14, int'(TIMEOUT) + 1, 32'h8765_4321);
        run_load(32'h0006_0000, 1'b0, 6'd16, int'(TIMEOUT) + 2, 32'h0BAD_0BAD);

        // random mix of stores and loads over a small address pool
        for (int i = 0; i < 30; i++) begin
            a = 32'h0008_0000 + 32'($urandom_range(0, 7) << 2);
            if ($urandom_range(0, 9) < 3) begin
                run_store(a, $urandom, 1'($urandom_range(0, 1)));
            end else begin
                if ($urandom_range(0, 9) < 8) lat = int'($urandom_range(1, 6));
                else lat = (($urandom_range(0, 1) == 0) ? 0 : int'(TIMEOUT));
                run_load(a, 1'($urandom_range(0, 1)), 6'($urandom), lat, $urandom);
            end
        end

        // reset while waiting on memory: request dropped, late data ignored
        repeat (4) @(posedge clk);
        rq.delete();
        wq.delete();
        m0      = mem_req_cnt;
        mem_lat = 6;
        do_req(1'b0, 32'h0009_0000, '0, 1'b0, 6'd33, acc);
        repeat (4) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        n_hit  = 0;
        n_miss = 0;
        repeat (15) @(negedge clk);
        check_eq("rstwait_resp_count", 32'(rq.size()), 32'd0);
        check_eq("rstwait_wr_count", 32'(wq.size()), 32'd0);
        check_eq("rstwait_mem_req", 32'(mem_req_cnt - m0), 32'd1);
        check_eq("rstwait_ld_ready", 32'(bus.ld_ready), 32'd1);
        check_eq("rstwait_counters", 32'({hit_cnt, miss_cnt}), 32'd0);

        // saturation: five hits on a narrow counter
        for (int i = 0; i < 5; i++) begin
            run_load(32'h0000_2040, 1'b0, 6'(20 + i), 1, 32'h0);
        end
        check_eq("hit_saturated", 32'(hit_cnt), 32'(CNT_MAX));

        // arbitration with both requesters held valid after reset
        pulse_reset();
        repeat (2) @(posedge clk);
        gq.delete();
        rq.delete();
        #1;
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h0000_2040; bus.ld_size = 1'b0; bus.ld_tag = 6'd40;
        bus.st_valid = 1'b1; bus.st_addr = 32'h0000_3000; bus.st_data = 32'h0000_0055; bus.st_size = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (gq.size() >= 6) break;
        end
        #1;
        bus.ld_valid = 1'b0;
        bus.st_valid = 1'b0;
        repeat (10) @(negedge clk);
        model_cache[32'h0000_3000] = 32'h0000_0055;
        check_eq("arb_grant_count", 32'(gq.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("arb_grant_%0d", i), (gq.size() > i) ? 32'(gq[i]) : 32'hx, 32'(i % 2));
        end
        check_eq("arb_resp_count", 32'(rq.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("arb_resp_data_%0d", i), (rq.size() > i) ? rq[i].data : 32'hx,
                     ext(model_cache[32'h0000_2040], 1'b0));
        end
        check_eq("arb_hit_cnt", 32'(hit_cnt), 32'(sat(3)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
